aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Iterative AES-128 encryption controller that runs the full 10-round cipher over one shared `sub_bytes` instance. The S-box array is time-multiplexed between the on-the-fly key schedule (SubWord) and the state path (SubBytes), so each round takes two cycles. It sits above the existing combinational round primitives (`sub_bytes`, ShiftRows, MixColumns, AddRoundKey) and is the top of the encryption datapath.

## Interface
- No parameters. Key size is fixed at 128 bits and round count at 10.
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  request to encrypt; sampled only when `o_busy`=0.
- `i_plaintext`  in  128  input block; byte 0 is at [127:120].
- `i_key`  in  128  cipher key; w0 is at [127:96] and w3 at [31:0].
- `o_busy`  out  1  high from the edge that accepts a start through the DONE cycle, inclusive.
- `o_done`  out  1  one-cycle pulse; `o_ciphertext` is valid in that cycle.
- `o_ciphertext`  out  128  result; held until the next accepted start.

## Operation
- FSM states: IDLE, KEY, STATE, DONE. Reset value is IDLE.
- Reset values: `o_busy`=0, `o_done`=0, `o_ciphertext`=0. State, round-key, round and rcon registers are 0.
- **IDLE, start accepted (`i_start`=1):**
  - state ← `i_plaintext` ^ `i_key`
  - rk ← `i_key`
  - rcon ← 8'h01
  - round ← 1
  - next state KEY
  - `i_plaintext` and `i_key` are sampled only at this edge.
- **KEY:**
  - S-box input mux = {RotWord(rk[31:0]), 96'h0}.
  - temp = top 32 bits of the `sub_bytes` output ^ {rcon, 24'h0}.
  - rk ← {w0^temp, w1^w0', w2^w1', w3^w2'}, where wN' is the new word N.
  - rcon ← xtime(rcon): shift left 1, XOR 8'h1b on carry-out.
  - Next state STATE.
- **STATE:**
  - S-box input mux = state.
  - Rounds 1–9: state ← MixColumns(ShiftRows(SB)) ^ rk.
  - Round 10: state ← ShiftRows(SB) ^ rk. MixColumns is bypassed.
  - If round<10: round ← round+1 and next state KEY.
  - If round=10: `o_ciphertext` ← new state value and next state DONE.
- **DONE:**
  - `o_done`=1.
  - Next state IDLE unconditionally.
- The `sub_bytes` input is driven only by the KEY/STATE mux. In IDLE and DONE it is 0.
- `i_start` while `o_busy`=1 is ignored, with no queueing.
- rcon sequence over the 10 KEY cycles: 01,02,04,08,10,20,40,80,1b,36.
- round is a 4-bit counter that never exceeds 10.

## Timing
- Start sampled at edge E0; KEY on E0→E1; STATE on E1→E2, and so on. Round 10 STATE ends at E20, where DONE is entered.
- `o_done` is high in the cycle after E20, i.e. 20 cycles after start sampling.
- DONE→IDLE at E21. The earliest next start is sampled at E22 if `i_start` is held high, giving a throughput of 1 block per 22 cycles.
- `o_busy` falls at E21. `o_ciphertext` changes only at E20 of a run.
- Asynchronous reset mid-run:
  - Immediately forces IDLE, `o_busy`=0, `o_done`=0, `o_ciphertext`=0.
  - The partial result is discarded, and `o_done` never fires for that run.
- Deassertion of `i_rst_n` is assumed synchronised externally. The first edge after release may accept a start.

## Structure
- Package `aes_pkg`, shared with decryption:
  - state/word typedefs
  - rcon initial constant 8'h01 and reduction constant 8'h1b
  - functions `xtime`, `rot_word`, `shift_rows`, `mix_columns`
- Exactly one sub-module instance: the existing `sub_bytes` (`i_initial_state` ← mux, `o_result_state` → SB).
- No second S-box array is permitted. Sharing it is the purpose of the block.

## Test plan
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → ct 3925841d02dc09fbdc118597196a0b32.
  - `o_done` exactly 20 cycles after start.
  - rk after the first KEY cycle = a0fafe1788542cb123a339392a6c7605.
- App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero pt and key → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Start held high across two different vectors:
  - second start sampled exactly 22 cycles after the first;
  - `i_start` pulses during busy are ignored;
  - `o_ciphertext` is stable between `o_done` pulses.
- Assert `i_rst_n`=0 at cycle 9 of a run:
  - outputs are 0 immediately;
  - no `o_done`;
  - a fresh App. B run afterwards produces the correct ct.
- Rcon wrap: check rcon equals 1b in round 9 and 36 in round 10 via the App. B round-key trace.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES types, constants and byte/word/state transforms shared by enc/dec
package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  word_t;
   typedef logic [7:0]   byte_t;

   localparam byte_t      RCON_INIT  = 8'h01;
   localparam byte_t      RCON_POLY  = 8'h1b;
   localparam logic [3:0] LAST_ROUND = 4'd10;

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   // Byte r+4c sits at [127-8*(r+4c) -: 8]; row r rotates left by r columns.
   function automatic state_t shift_rows(input state_t s);
      state_t r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
         end
      end
      return r;
   endfunction

   function automatic word_t mix_column(input word_t col);
      byte_t a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic state_t mix_columns(input state_t s);
      state_t r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
      end
      return r;
   endfunction

endpackage

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - combinational SubBytes over a 128-bit state
module sub_bytes
   import aes_pkg::*;
(
   input  logic [127:0] i_initial_state,
   output logic [127:0] o_result_state
);

   function automatic byte_t gf_mul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS affine transform.
   function automatic byte_t sbox(input byte_t x);
      byte_t x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      inv  = gf_mul(gf_mul(x240, x12), x2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   always_comb begin
      o_result_state = '0;
      for (int i = 0; i < 16; i++) begin
         o_result_state[8*i +: 8] = sbox(i_initial_state[8*i +: 8]);
      end
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryptor, one S-box array shared by key and state paths
module aes_round_ctrl
   import aes_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [127:0] i_plaintext,
   input  logic [127:0] i_key,
   output logic         o_busy,
   output logic         o_done,
   output logic [127:0] o_ciphertext
);

   typedef enum logic [1:0] {IDLE, KEY, STATE, DONE} fsm_e;

   fsm_e       fsm_q, fsm_d;
   state_t     state_q, state_d;
   state_t     rk_q, rk_d;
   state_t     ct_q, ct_d;
   byte_t      rcon_q, rcon_d;
   logic [3:0] round_q, round_d;

   state_t     sbox_in;
   state_t     sbox_out;
   state_t     sr_out;
   state_t     round_out;
   word_t      temp, w0n, w1n, w2n, w3n;

   sub_bytes u_sub_bytes (
      .i_initial_state (sbox_in),
      .o_result_state  (sbox_out)
   );

   // KEY cycles borrow the top word of the array for SubWord; STATE cycles use all of it.
   always_comb begin
      sbox_in = '0;
      case (fsm_q)
         KEY:     sbox_in = {rot_word(rk_q[31:0]), 96'h0};
         STATE:   sbox_in = state_q;
         default: sbox_in = '0;
      endcase
   end

   assign temp = sbox_out[127:96] ^ {rcon_q, 24'h0};
   assign w0n  = rk_q[127:96] ^ temp;
   assign w1n  = rk_q[95:64]  ^ w0n;
   assign w2n  = rk_q[63:32]  ^ w1n;
   assign w3n  = rk_q[31:0]   ^ w2n;

   assign sr_out    = shift_rows(sbox_out);
   assign round_out = (round_q == LAST_ROUND) ? (sr_out ^ rk_q) : (mix_columns(sr_out) ^ rk_q);

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rk_d    = rk_q;
      ct_d    = ct_q;
      rcon_d  = rcon_q;
      round_d = round_q;
      case (fsm_q)
         IDLE: begin
            if (i_start) begin
               state_d = i_plaintext ^ i_key;
               rk_d    = i_key;
               rcon_d  = RCON_INIT;
               round_d = 4'd1;
               fsm_d   = KEY;
            end
         end
         KEY: begin
            rk_d   = {w0n, w1n, w2n, w3n};
            rcon_d = xtime(rcon_q);
            fsm_d  = STATE;
         end
         STATE: begin
            state_d = round_out;
            if (round_q == LAST_ROUND) begin
               ct_d  = round_out;
               fsm_d = DONE;
            end else begin
               round_d = round_q + 4'd1;
               fsm_d   = KEY;
            end
         end
         DONE:    fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rk_q    <= '0;
         ct_q    <= '0;
         rcon_q  <= '0;
         round_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rk_q    <= rk_d;
         ct_q    <= ct_d;
         rcon_q  <= rcon_d;
         round_q <= round_d;
      end
   end

   assign o_busy       = (fsm_q != IDLE);
   assign o_done       = (fsm_q == DONE);
   assign o_ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed known-answer bench for aes_round_ctrl
module tb_aes_round_ctrl;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK9_B = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] pt = '0;
   logic [127:0] key = '0;
   logic         busy;
   logic         done;
   logic [127:0] ct;

   int n_assert = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   aes_round_ctrl dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_plaintext  (pt),
      .i_key        (key),
      .o_busy       (busy),
      .o_done       (done),
      .o_ciphertext (ct)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_block(input string tag, input logic [127:0] p, input logic [127:0] k,
                            input logic [127:0] c);
      int n;
      pt = p;
      key = k;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " busy_rise"}, 128'(busy), 128'(1));
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check({tag, " latency"}, 128'(n), 128'(20));
      check({tag, " ct"}, ct, c);
      tick();
      check({tag, " busy_fall"}, 128'(busy), 128'(0));
      check({tag, " ct_hold"}, ct, c);
   endtask

   initial begin
      int n;
      int m;
      int done_cnt;
      bit stable;
      bit idle_seen;

      #1;
      check("reset busy", 128'(busy), 128'(0));
      check("reset done", 128'(done), 128'(0));
      check("reset ct", ct, '0);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // App. B with round-key and rcon trace
      pt = PT_B;
      key = KEY_B;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
         if (n == 1)  check("B rk1", dut.rk_q, RK1_B);
         if (n == 16) check("B rcon r9", 128'(dut.rcon_q), 128'h1b);
         if (n == 17) check("B rk9", dut.rk_q, RK9_B);
         if (n == 18) check("B rcon r10", 128'(dut.rcon_q), 128'h36);
         if (n == 19) check("B rk10", dut.rk_q, RK10_B);
      end
      check("B latency", 128'(n), 128'(20));
      check("B ct", ct, CT_B);
      tick();
      check("B busy_fall", 128'(busy), 128'(0));

      run_block("C1", PT_C, KEY_C, CT_C);

      // all-zero vector with start pulses during busy, including the DONE cycle
      pt = '0;
      key = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         start = (n == 5 || n == 12);
         tick();
         n++;
      end
      check("Z latency", 128'(n), 128'(20));
      check("Z ct", ct, CT_Z);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("Z busy_fall", 128'(busy), 128'(0));
      tick();
      check("Z no_queue", 128'(busy), 128'(0));

      // start held high across two vectors
      pt = PT_B;
      key = KEY_B;
      start = 1'b1;
      tick();
      pt = PT_C;
      key = KEY_C;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check("held first latency", 128'(n), 128'(20));
      check("held first ct", ct, CT_B);
      m = 0;
      stable = 1'b1;
      idle_seen = 1'b0;
      do begin
         tick();
         m++;
         if (m == 1 && !busy) idle_seen = 1'b1;
         if (!done && ct !== CT_B) stable = 1'b0;
      end while (!done && m < 60);
      start = 1'b0;
      check("held restart spacing", 128'(m), 128'(22));
      check("held idle gap", 128'(idle_seen), 128'(1));
      check("held ct stable", 128'(stable), 128'(1));
      check("held second ct", ct, CT_C);
      tick();

      // asynchronous reset at cycle 9 of a run
      pt = PT_C;
      key = KEY_C;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst busy", 128'(busy), 128'(0));
      check("rst done", 128'(done), 128'(0));
      check("rst ct", ct, '0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      done_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done) done_cnt++;
      end
      check("rst no_done", 128'(done_cnt), 128'(0));
      check("rst ct_zero", ct, '0);

      run_block("B after rst", PT_B, KEY_B, CT_B);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
